// File: rtl/hazard_ctrl_gen_if.sv
// hazard_ctrl_gen_if: pipeline status inputs and stall/flush controls for the hazard controller
interface hazard_ctrl_gen_if #(parameter int REGW = 5, parameter int NSRC = 2, parameter int CNTW = 32);
    logic [NSRC*REGW-1:0] i_src_d;
    logic [NSRC-1:0]      i_src_v_d;
    logic [REGW-1:0]      i_dst_e;
    logic                 i_regwrite_e;
    logic                 i_memtoreg_e;
    logic [REGW-1:0]      i_dst_m;
    logic                 i_memtoreg_m;
    logic                 i_branch_d;
    logic                 i_jumpreg_d;
    logic                 i_instrack_f;
    logic                 i_dataack_m;
    logic                 i_hiloaccess_d;
    logic                 i_mdstart_e;
    logic                 i_exc_req;
    logic                 i_stat_clr;
    logic                 o_stall_f;
    logic                 o_stall_d;
    logic                 o_stall_e;
    logic                 o_stall_m;
    logic                 o_stall_w;
    logic                 o_flush_d;
    logic                 o_flush_e;
    logic                 o_flush_m;
    logic                 o_exc_redirect;
    logic                 o_md_busy;
    logic                 o_ex_cleared;
    logic [CNTW-1:0]      o_stall_count;
    modport master (
        output i_src_d, i_src_v_d, i_dst_e, i_regwrite_e, i_memtoreg_e, i_dst_m, i_memtoreg_m,
               i_branch_d, i_jumpreg_d, i_instrack_f, i_dataack_m, i_hiloaccess_d, i_mdstart_e,
               i_exc_req, i_stat_clr,
        input  o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w, o_flush_d, o_flush_e,
               o_flush_m, o_exc_redirect, o_md_busy, o_ex_cleared, o_stall_count
    );
    modport slave (
        input  i_src_d, i_src_v_d, i_dst_e, i_regwrite_e, i_memtoreg_e, i_dst_m, i_memtoreg_m,
               i_branch_d, i_jumpreg_d, i_instrack_f, i_dataack_m, i_hiloaccess_d, i_mdstart_e,
               i_exc_req, i_stat_clr,
        output o_stall_f, o_stall_d, o_stall_e, o_stall_m, o_stall_w, o_flush_d, o_flush_e,
               o_flush_m, o_exc_redirect, o_md_busy, o_ex_cleared, o_stall_count
    );
endinterface

// File: rtl/hazard_ctrl_gen.sv
// hazard_ctrl_gen: 5-stage pipeline hazard controller with mult/div tracker,
// deferred exception flush and saturating stall counter
module hazard_ctrl_gen #(
    parameter int REGW       = 5,
    parameter int NSRC       = 2,
    parameter int MD_LAT     = 32,
    parameter int ZERO_GUARD = 1,
    parameter int CNTW       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_gen_if.slave   bus
);
    localparam int MDW = $clog2(MD_LAT + 1);
    typedef enum logic {RUN, EXC_WAIT} state_t;
    state_t          r_state, w_state_nxt;
    logic [MDW-1:0]  r_md_cnt;
    logic            r_ex_cleared;
    logic [CNTW-1:0] r_stall_count;
    logic            w_hit_e, w_hit_m, w_lwstall, w_brstall, w_imiss, w_dmiss, w_mdstall;
    logic            w_exc_flush, w_stall_fd, w_stall_e, w_stall_mw, w_md_busy;

    function automatic logic match(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
        return (a == b) && !((ZERO_GUARD != 0) && (b == '0));
    endfunction

    always_comb begin
        w_hit_e = 1'b0;
        w_hit_m = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_hit_e = w_hit_e | (bus.i_src_v_d[i] & match(bus.i_src_d[i*REGW +: REGW], bus.i_dst_e));
            w_hit_m = w_hit_m | (bus.i_src_v_d[i] & match(bus.i_src_d[i*REGW +: REGW], bus.i_dst_m));
        end
    end

    assign w_md_busy = (r_md_cnt != '0);
    assign w_lwstall = bus.i_memtoreg_e & w_hit_e;
    assign w_brstall = (bus.i_branch_d | bus.i_jumpreg_d) &
                       ((bus.i_regwrite_e & w_hit_e) | (bus.i_memtoreg_m & w_hit_m));
    assign w_imiss   = ~bus.i_instrack_f;
    assign w_dmiss   = ~bus.i_dataack_m;
    assign w_mdstall = bus.i_hiloaccess_d & (w_md_busy | bus.i_mdstart_e);

    // An exception arriving under a D-cache miss waits until M is released
    always_comb begin
        w_exc_flush = (r_state == RUN) ? (bus.i_exc_req & ~w_dmiss) : ~w_dmiss;
        w_state_nxt = (r_state == RUN) ? ((bus.i_exc_req & w_dmiss) ? EXC_WAIT : RUN)
                                       : (w_dmiss ? EXC_WAIT : RUN);
    end

    assign w_stall_fd = ~w_exc_flush & (w_lwstall | w_brstall | w_mdstall | w_imiss | w_dmiss);
    assign w_stall_e  = ~w_exc_flush & (w_imiss | w_dmiss);
    assign w_stall_mw = ~w_exc_flush & w_dmiss;

    assign bus.o_stall_f      = rst_n & w_stall_fd;
    assign bus.o_stall_d      = rst_n & w_stall_fd;
    assign bus.o_stall_e      = rst_n & w_stall_e;
    assign bus.o_stall_m      = rst_n & w_stall_mw;
    assign bus.o_stall_w      = rst_n & w_stall_mw;
    assign bus.o_flush_d      = ~rst_n | w_exc_flush;
    assign bus.o_flush_e      = ~rst_n | w_exc_flush | (w_stall_fd & ~w_stall_e);
    assign bus.o_flush_m      = ~rst_n | w_exc_flush | (w_stall_e & ~w_stall_mw);
    assign bus.o_exc_redirect = rst_n & w_exc_flush;
    assign bus.o_md_busy      = w_md_busy;
    assign bus.o_ex_cleared   = r_ex_cleared;
    assign bus.o_stall_count  = r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_md_cnt      <= '0;
            r_ex_cleared  <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_md_cnt      <= w_exc_flush ? '0 :
                             (bus.i_mdstart_e & ~w_stall_e) ? MDW'(MD_LAT) :
                             w_md_busy ? r_md_cnt - MDW'(1) : r_md_cnt;
            r_ex_cleared  <= (bus.o_flush_e | r_ex_cleared) & w_stall_fd;
            r_stall_count <= bus.i_stat_clr ? '0 :
                             (w_stall_fd & ~&r_stall_count) ? r_stall_count + CNTW'(1) : r_stall_count;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// tb_hazard_ctrl_gen: directed checks of the hazard controller (MD_LAT=4, CNTW=3, ZERO_GUARD=1)
module tb_hazard_ctrl_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    hazard_ctrl_gen_if #(.REGW(5), .NSRC(2), .CNTW(3)) bus ();
    hazard_ctrl_gen #(.REGW(5), .NSRC(2), .MD_LAT(4), .ZERO_GUARD(1), .CNTW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.i_src_d        = '0;
        bus.i_src_v_d      = '0;
        bus.i_dst_e        = '0;
        bus.i_regwrite_e   = 1'b0;
        bus.i_memtoreg_e   = 1'b0;
        bus.i_dst_m        = '0;
        bus.i_memtoreg_m   = 1'b0;
        bus.i_branch_d     = 1'b0;
        bus.i_jumpreg_d    = 1'b0;
        bus.i_instrack_f   = 1'b1;
        bus.i_dataack_m    = 1'b1;
        bus.i_hiloaccess_d = 1'b0;
        bus.i_mdstart_e    = 1'b0;
        bus.i_exc_req      = 1'b0;
        bus.i_stat_clr     = 1'b0;
    endtask

    initial begin
        idle();
        #2;
        chk("rst_stallF", 32'(bus.o_stall_f), 0);
        chk("rst_flushD", 32'(bus.o_flush_d), 1);
        chk("rst_flushE", 32'(bus.o_flush_e), 1);
        chk("rst_flushM", 32'(bus.o_flush_m), 1);
        chk("rst_redirect", 32'(bus.o_exc_redirect), 0);
        chk("rst_count", 32'(bus.o_stall_count), 0);
        chk("rst_md_busy", 32'(bus.o_md_busy), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("idle_stallF", 32'(bus.o_stall_f), 0);
        chk("idle_flushD", 32'(bus.o_flush_d), 0);
        chk("idle_flushE", 32'(bus.o_flush_e), 0);
        // load-use
        tick();
        bus.i_memtoreg_e = 1'b1; bus.i_dst_e = 5'd8; bus.i_src_d = {5'd9, 5'd8}; bus.i_src_v_d = 2'b11;
        #1;
        chk("lw_stallF", 32'(bus.o_stall_f), 1);
        chk("lw_stallD", 32'(bus.o_stall_d), 1);
        chk("lw_flushE", 32'(bus.o_flush_e), 1);
        chk("lw_stallE", 32'(bus.o_stall_e), 0);
        chk("lw_flushM", 32'(bus.o_flush_m), 0);
        tick(); idle(); #1;
        chk("lw_bubble_stallF", 32'(bus.o_stall_f), 0);
        tick(); #1;
        chk("lw_exc_cleared_low", 32'(bus.o_ex_cleared), 0);
        bus.i_memtoreg_e = 1'b1; bus.i_dst_e = 5'd8; bus.i_src_d = {5'd9, 5'd8}; bus.i_src_v_d = 2'b10;
        #1;
        chk("lw_invalid_src", 32'(bus.o_stall_f), 0);
        // zero register guard
        bus.i_dst_e = 5'd0; bus.i_src_d = '0; bus.i_src_v_d = 2'b11;
        #1;
        chk("zero_lw", 32'(bus.o_stall_f), 0);
        bus.i_memtoreg_e = 1'b0; bus.i_branch_d = 1'b1; bus.i_regwrite_e = 1'b1;
        #1;
        chk("zero_br", 32'(bus.o_stall_f), 0);
        bus.i_dst_e = 5'd9; bus.i_src_d = {5'd9, 5'd8};
        #1;
        chk("br_regwriteE", 32'(bus.o_stall_d), 1);
        chk("br_flushE", 32'(bus.o_flush_e), 1);
        bus.i_regwrite_e = 1'b0; bus.i_memtoreg_m = 1'b1; bus.i_dst_m = 5'd8;
        #1;
        chk("br_loadM", 32'(bus.o_stall_d), 1);
        bus.i_branch_d = 1'b0; bus.i_jumpreg_d = 1'b1;
        #1;
        chk("jr_loadM", 32'(bus.o_stall_d), 1);
        bus.i_jumpreg_d = 1'b0;
        #1;
        chk("loadM_no_branch", 32'(bus.o_stall_d), 0);
        // exception deferred by D-cache miss
        tick(); idle();
        bus.i_dataack_m = 1'b0; bus.i_exc_req = 1'b1;
        #1;
        chk("dm1_stallF", 32'(bus.o_stall_f), 1);
        chk("dm1_stallE", 32'(bus.o_stall_e), 1);
        chk("dm1_stallM", 32'(bus.o_stall_m), 1);
        chk("dm1_stallW", 32'(bus.o_stall_w), 1);
        chk("dm1_flushD", 32'(bus.o_flush_d), 0);
        chk("dm1_flushE", 32'(bus.o_flush_e), 0);
        chk("dm1_flushM", 32'(bus.o_flush_m), 0);
        chk("dm1_redirect", 32'(bus.o_exc_redirect), 0);
        for (int c = 2; c <= 4; c++) begin
            tick();
            bus.i_exc_req = (c == 3);
            #1;
            chk("dm_wait_stallW", 32'(bus.o_stall_w), 1);
            chk("dm_wait_redirect", 32'(bus.o_exc_redirect), 0);
        end
        tick();
        bus.i_exc_req = 1'b0; bus.i_dataack_m = 1'b1;
        #1;
        chk("dm5_redirect", 32'(bus.o_exc_redirect), 1);
        chk("dm5_flushD", 32'(bus.o_flush_d), 1);
        chk("dm5_flushE", 32'(bus.o_flush_e), 1);
        chk("dm5_flushM", 32'(bus.o_flush_m), 1);
        chk("dm5_stallF", 32'(bus.o_stall_f), 0);
        chk("dm5_stallW", 32'(bus.o_stall_w), 0);
        tick(); #1;
        chk("dm6_redirect", 32'(bus.o_exc_redirect), 0);
        bus.i_exc_req = 1'b1; bus.i_instrack_f = 1'b0;
        #1;
        chk("exc_now_redirect", 32'(bus.o_exc_redirect), 1);
        chk("exc_now_stallF", 32'(bus.o_stall_f), 0);
        chk("exc_now_stallE", 32'(bus.o_stall_e), 0);
        // mult/div busy tracking
        tick(); idle();
        bus.i_mdstart_e = 1'b1; bus.i_hiloaccess_d = 1'b1;
        #1;
        chk("md_start_stallD", 32'(bus.o_stall_d), 1);
        chk("md_start_busy", 32'(bus.o_md_busy), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            bus.i_mdstart_e = 1'b0;
            #1;
            chk("md_busy_stallD", 32'(bus.o_stall_d), 1);
            chk("md_busy", 32'(bus.o_md_busy), 1);
        end
        tick(); #1;
        chk("md_done_stallD", 32'(bus.o_stall_d), 0);
        chk("md_done_busy", 32'(bus.o_md_busy), 0);
        bus.i_hiloaccess_d = 1'b0; bus.i_mdstart_e = 1'b1;
        tick();
        bus.i_mdstart_e = 1'b0;
        #1;
        chk("md_exc_busy1", 32'(bus.o_md_busy), 1);
        tick();
        bus.i_exc_req = 1'b1;
        #1;
        chk("md_exc_redirect", 32'(bus.o_exc_redirect), 1);
        tick();
        bus.i_exc_req = 1'b0;
        #1;
        chk("md_exc_cleared", 32'(bus.o_md_busy), 0);
        bus.i_exc_req = 1'b1; bus.i_mdstart_e = 1'b1;
        tick(); idle(); #1;
        chk("md_flush_beats_load", 32'(bus.o_md_busy), 0);
        // I-cache miss and ex_cleared
        bus.i_instrack_f = 1'b0;
        #1;
        chk("im_stallF", 32'(bus.o_stall_f), 1);
        chk("im_stallE", 32'(bus.o_stall_e), 1);
        chk("im_stallM", 32'(bus.o_stall_m), 0);
        chk("im_flushM", 32'(bus.o_flush_m), 1);
        chk("im_flushE", 32'(bus.o_flush_e), 0);
        tick(); idle();
        bus.i_memtoreg_e = 1'b1; bus.i_dst_e = 5'd8; bus.i_src_d = {5'd9, 5'd8}; bus.i_src_v_d = 2'b01;
        #1;
        chk("exc_lw_before", 32'(bus.o_ex_cleared), 0);
        tick(); idle();
        bus.i_instrack_f = 1'b0;
        #1;
        chk("exc_rise", 32'(bus.o_ex_cleared), 1);
        tick(); idle(); #1;
        chk("exc_hold", 32'(bus.o_ex_cleared), 1);
        tick(); #1;
        chk("exc_fall", 32'(bus.o_ex_cleared), 0);
        // saturating stall counter
        bus.i_stat_clr = 1'b1;
        tick();
        bus.i_stat_clr = 1'b0;
        #1;
        chk("cnt_clr", 32'(bus.o_stall_count), 0);
        bus.i_instrack_f = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        chk("cnt_3", 32'(bus.o_stall_count), 3);
        for (int c = 0; c < 7; c++) tick();
        chk("cnt_sat", 32'(bus.o_stall_count), 7);
        bus.i_stat_clr = 1'b1;
        tick();
        bus.i_stat_clr = 1'b0;
        #1;
        chk("cnt_clr_wins", 32'(bus.o_stall_count), 0);
        tick(); tick();
        chk("cnt_2", 32'(bus.o_stall_count), 2);
        // reset mid-run abandons pending exception and busy unit
        idle();
        bus.i_mdstart_e = 1'b1;
        tick();
        bus.i_mdstart_e = 1'b0; bus.i_dataack_m = 1'b0; bus.i_exc_req = 1'b1;
        tick();
        bus.i_exc_req = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(bus.o_md_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(bus.o_stall_count), 0);
        chk("arst_busy", 32'(bus.o_md_busy), 0);
        chk("arst_stallW", 32'(bus.o_stall_w), 0);
        chk("arst_flushD", 32'(bus.o_flush_d), 1);
        tick();
        rst_n = 1'b1; bus.i_dataack_m = 1'b1;
        #1;
        chk("arst_exc_dropped", 32'(bus.o_exc_redirect), 0);
        chk("arst_flushD_rel", 32'(bus.o_flush_d), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
